// File: rtl/vram_write_buffer_pkg.sv
// rtl/vram_write_buffer_pkg.sv - shared constants and helpers for the VRAM write buffer
//
// Purpose: VRAM geometry shared by the CPU write path and the GPU VRAM interface,
//          plus a helper that sizes level counters for a given FIFO depth.
// Contents:
//   VRAM_ADDR_WIDTH  VRAM byte-address width
//   VRAM_DATA_WIDTH  VRAM data width (bytes)
//   level_width()    bits needed to hold a level of 0..depth inclusive
package vram_write_buffer_pkg;

  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_DATA_WIDTH = 8;

  // A level must represent DEPTH itself, hence the extra bit over the pointer width.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_write_buffer_sync_fifo.sv
// rtl/vram_write_buffer_sync_fifo.sv - single-clock FIFO with separate level counter
//
// Purpose: stores WIDTH-bit entries in DEPTH slots. Pointers wrap modulo DEPTH and the
//          occupancy is tracked in its own counter, so full/empty come straight from it.
//          The caller must never push when full unless it pops at the same edge, and
//          must never pop when empty.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset (pointers and level to 0)
//   push_i       in   write push_data_i at this edge
//   push_data_i  in   entry to store
//   pop_i        in   retire the head entry at this edge
//   pop_data_o   out  current head entry (valid while !empty_o)
//   level_o      out  entries held, 0..DEPTH
//   full_o       out  level_o == DEPTH
//   empty_o      out  level_o == 0
module sync_fifo_m
  import vram_write_buffer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = level_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     pop_data_o,
  output logic [CNT_WIDTH-1:0] level_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + CNT_WIDTH'(1);
      2'b01:   level_d = level_q - CNT_WIDTH'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign full_o     = (level_q == CNT_WIDTH'(DEPTH));
  assign empty_o    = (level_q == '0);

endmodule

// File: rtl/vram_write_buffer.sv
// rtl/vram_write_buffer.sv - CPU byte-write buffer draining into VRAM around GPU fetches
//
// Purpose: queues CPU byte writes and replays them to VRAM only in cycles the GPU has
//          not claimed. CPU writes are accepted whenever space exists (or a slot frees
//          at the same edge); writes arriving to a full, non-draining buffer are dropped
//          and flagged in a sticky overflow bit.
// Ports:
//   clk           in   pixel clock, single domain
//   rst           in   asynchronous active-low reset
//   cpu_we        in   one-cycle write request
//   cpu_address   in   write address, valid with cpu_we
//   cpu_data      in   write data, valid with cpu_we
//   gpu_busy      in   GPU owns the VRAM port in the next cycle
//   ovf_clear     in   clears the sticky overflow
//   vram_address  out  registered write address to VRAM
//   vram_data     out  registered write data to VRAM
//   vram_we       out  registered write strobe, one cycle per drained entry
//   full          out  level == DEPTH
//   empty         out  level == 0
//   level         out  entries held, 0..DEPTH
//   overflow      out  sticky: a write was dropped
module vram_write_buffer
  import vram_write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]            cpu_data,
  input  logic                  gpu_busy,
  input  logic                  ovf_clear,
  output logic [ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]            vram_data,
  output logic                  vram_we,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  overflow
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + 8;

  logic                   push, pop, drop;
  logic [ENTRY_WIDTH-1:0] head;
  logic                   fifo_full, fifo_empty;

  logic [ADDR_WIDTH-1:0]  vram_address_q, vram_address_d;
  logic [7:0]             vram_data_q, vram_data_d;
  logic                   vram_we_q, vram_we_d;
  logic                   overflow_q, overflow_d;

  // Draining is decided from stored entries only, so a write pushed at this edge
  // cannot also be drained at this edge. A pop frees the slot a full-buffer push needs.
  assign pop  = !fifo_empty && !gpu_busy;
  assign push = cpu_we && (!fifo_full || pop);
  assign drop = cpu_we && fifo_full && !pop;

  sync_fifo_m #(
    .WIDTH     (ENTRY_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({cpu_address, cpu_data}),
    .pop_i       (pop),
    .pop_data_o  (head),
    .level_o     (level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    vram_we_d      = pop;
    vram_address_d = vram_address_q;
    vram_data_d    = vram_data_q;
    if (pop) begin
      vram_address_d = head[ENTRY_WIDTH-1:8];
      vram_data_d    = head[7:0];
    end
    // A drop at the same edge as a clear must stay visible.
    overflow_d = overflow_q;
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vram_address_q <= '0;
      vram_data_q    <= '0;
      vram_we_q      <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      vram_address_q <= vram_address_d;
      vram_data_q    <= vram_data_d;
      vram_we_q      <= vram_we_d;
      overflow_q     <= overflow_d;
    end
  end

  assign vram_address = vram_address_q;
  assign vram_data    = vram_data_q;
  assign vram_we      = vram_we_q;
  assign overflow     = overflow_q;
  assign full         = fifo_full;
  assign empty        = fifo_empty;

endmodule

// File: tb/tb_vram_write_buffer.sv
// tb/tb_vram_write_buffer.sv - directed self-checking bench for vram_write_buffer
module tb_vram_write_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [7:0]  cpu_data = '0;
  logic        gpu_busy = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [15:0] vram_address;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int we_seen;

  vram_write_buffer #(
    .ADDR_WIDTH (16),
    .DEPTH      (8),
    .CNT_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_we       (cpu_we),
    .cpu_address  (cpu_address),
    .cpu_data     (cpu_data),
    .gpu_busy     (gpu_busy),
    .ovf_clear    (ovf_clear),
    .vram_address (vram_address),
    .vram_data    (vram_data),
    .vram_we      (vram_we),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    cpu_we      = 1'b1;
    cpu_address = a;
    cpu_data    = d;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_addr", 32'(vram_address), 32'd0);
    chk("rst_data", 32'(vram_data), 32'd0);
    rst = 1'b1;
    tick();

    // Single write: strobe appears in the cycle after edge N+1
    write(16'h0123, 8'hA5);
    tick();
    cpu_we = 1'b0;
    chk("single_lvl1", 32'(level), 32'd1);
    chk("single_we_n", 32'(vram_we), 32'd0);
    tick();
    chk("single_we", 32'(vram_we), 32'd1);
    chk("single_addr", 32'(vram_address), 32'h123);
    chk("single_data", 32'(vram_data), 32'hA5);
    chk("single_empty", 32'(empty), 32'd1);
    tick();
    chk("single_we_off", 32'(vram_we), 32'd0);

    // Fill while GPU busy
    gpu_busy = 1'b1;
    we_seen  = 0;
    for (int i = 0; i < 8; i++) begin
      write(16'h0200 + 16'(i), 8'h10 + 8'(i));
      tick();
      if (vram_we) we_seen++;
    end
    chk("fill_no_we", 32'(we_seen), 32'd0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    write(16'h02FF, 8'hEE);
    tick();
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_level", 32'(level), 32'd8);

    // Drop coinciding with clear keeps overflow; clear alone clears it
    write(16'h02FE, 8'hED);
    ovf_clear = 1'b1;
    tick();
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    cpu_we = 1'b0;
    tick();
    ovf_clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_level", 32'(level), 32'd8);
    chk("busy_no_we", 32'(vram_we), 32'd0);

    // Release GPU with a write at the same edge: full push+pop
    gpu_busy = 1'b0;
    write(16'h0300, 8'h77);
    tick();
    cpu_we = 1'b0;
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("drain0_we", 32'(vram_we), 32'd1);
    chk("drain0_addr", 32'(vram_address), 32'h200);
    chk("drain0_data", 32'(vram_data), 32'h10);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("drain_we", 32'(vram_we), 32'd1);
      chk("drain_addr", 32'(vram_address), 32'h200 + 32'(i));
      chk("drain_data", 32'(vram_data), 32'h10 + 32'(i));
    end
    tick();
    chk("drain_last_we", 32'(vram_we), 32'd1);
    chk("drain_last_addr", 32'(vram_address), 32'h300);
    chk("drain_last_data", 32'(vram_data), 32'h77);
    chk("drain_empty", 32'(empty), 32'd1);
    tick();
    chk("drain_done_we", 32'(vram_we), 32'd0);

    // Alternating gpu_busy with a write on each busy cycle
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        gpu_busy = 1'b1;
        write(16'h0400 + 16'(k / 2), 8'h50 + 8'(k / 2));
      end else begin
        gpu_busy = 1'b0;
        cpu_we   = 1'b0;
      end
      tick();
      if (k % 2 == 0) begin
        chk("alt_busy_we", 32'(vram_we), 32'd0);
      end else begin
        chk("alt_we", 32'(vram_we), 32'd1);
        chk("alt_addr", 32'(vram_address), 32'h400 + 32'(k / 2));
        chk("alt_data", 32'(vram_data), 32'h50 + 32'(k / 2));
      end
    end
    cpu_we   = 1'b0;
    gpu_busy = 1'b0;
    chk("alt_ovf", 32'(overflow), 32'd0);
    chk("alt_empty", 32'(empty), 32'd1);

    // Reset mid-drain with level 3
    gpu_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write(16'h0500 + 16'(i), 8'h60 + 8'(i));
      tick();
    end
    cpu_we   = 1'b0;
    gpu_busy = 1'b0;
    tick();
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_we", 32'(vram_we), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", 32'(vram_we), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_addr", 32'(vram_address), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_we", 32'(vram_we), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
